// File: rtl/emif_avmm_pipe_bridge_if.sv
// Avalon-MM bus bundle used on both sides of the EMIF pipeline bridge.
// The master drives the command fields and the slave returns stall and read data.
interface emif_avmm_pipe_bridge_if #(
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned ADDR_W  = 25,
  parameter int unsigned BURST_W = 7
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic [BURST_W-1:0]  burstcount;
  logic [DATA_W-1:0]   writedata;
  logic [ADDR_W-1:0]   address;
  logic                write;
  logic                read;
  logic [BE_W-1:0]     byteenable;
  logic                debugaccess;

  modport master (
    input  waitrequest, readdata, readdatavalid,
    output burstcount, writedata, address, write, read, byteenable, debugaccess
  );

  modport slave (
    output waitrequest, readdata, readdatavalid,
    input  burstcount, writedata, address, write, read, byteenable, debugaccess
  );
endinterface

// File: rtl/emif_avmm_pipe_bridge.sv
// Avalon-MM pipeline bridge toward EMIF: 2-entry command skid buffer, registered read
// response, read-word credit limit and a PR freeze/drain handshake.
module emif_avmm_pipe_bridge #(
  parameter int unsigned DATA_W            = 512,
  parameter int unsigned ADDR_W            = 25,
  parameter int unsigned BURST_W           = 7,
  parameter int unsigned MAX_PENDING_WORDS = 256
) (
  input  logic                                   emif_clk,
  input  logic                                   usr_reset_n,
  input  logic                                   freeze_req,
  output logic                                   freeze_ack,
  output logic [$clog2(MAX_PENDING_WORDS+1)-1:0] pending_words,
  emif_avmm_pipe_bridge_if.slave                 s0,
  emif_avmm_pipe_bridge_if.master                m0
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned PW_W = $clog2(MAX_PENDING_WORDS + 1);
  localparam int unsigned CW   = ((PW_W > BURST_W) ? PW_W : BURST_W) + 1;

  typedef struct packed {
    logic               read;
    logic               write;
    logic [ADDR_W-1:0]  address;
    logic [BURST_W-1:0] burstcount;
    logic [DATA_W-1:0]  writedata;
    logic [BE_W-1:0]    byteenable;
    logic               debugaccess;
  } cmd_t;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FROZEN} state_t;

  cmd_t               head_q, tail_q, in_c;
  logic [1:0]         count_q;
  logic               full_c, empty_c, push_c, pop_c, wait_c;
  logic [BURST_W-1:0] eff_burst_c, wr_beats_left_q;
  logic [CW-1:0]      credit_sum_c, pend_next_c;
  logic               rdv_q;
  logic [DATA_W-1:0]  rdata_q;
  state_t             state_q, state_d;
  logic               ack_d;

  always_comb begin
    in_c.read        = s0.read;
    in_c.write       = s0.write;
    in_c.address     = s0.address;
    in_c.burstcount  = s0.burstcount;
    in_c.writedata   = s0.writedata;
    in_c.byteenable  = s0.byteenable;
    in_c.debugaccess = s0.debugaccess;
  end

  assign full_c       = (count_q == 2'd2);
  assign empty_c      = (count_q == 2'd0);
  assign eff_burst_c  = (s0.burstcount == '0) ? BURST_W'(1) : s0.burstcount;
  assign credit_sum_c = CW'(pending_words) + CW'(eff_burst_c);

  // Stall depends only on registered state and the offered read/burstcount.
  assign wait_c = !usr_reset_n || full_c || (state_q != ST_RUN) ||
                  (freeze_req && ((wr_beats_left_q == '0) || s0.read)) ||
                  (s0.read && (credit_sum_c > CW'(MAX_PENDING_WORDS)));

  assign push_c = (s0.read || s0.write) && !wait_c;
  assign pop_c  = !empty_c && !m0.waitrequest;

  // Head register is zeroed when empty so m0 command strobes come straight from flops.
  always_ff @(posedge emif_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      case ({push_c, pop_c})
        2'b10: begin
          if (empty_c) head_q <= in_c;
          else         tail_q <= in_c;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= full_c ? tail_q : '0;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (full_c) begin
            head_q <= tail_q;
            tail_q <= in_c;
          end else begin
            head_q <= in_c;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge emif_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      wr_beats_left_q <= '0;
    end else if (push_c && s0.write) begin
      wr_beats_left_q <= (wr_beats_left_q == '0) ? eff_burst_c - BURST_W'(1)
                                                 : wr_beats_left_q - BURST_W'(1);
    end
  end

  // A return with nothing outstanding is forwarded but never underflows the count.
  always_comb begin
    pend_next_c = CW'(pending_words);
    if (push_c && s0.read) pend_next_c = pend_next_c + CW'(eff_burst_c);
    if (m0.readdatavalid && (pend_next_c != '0)) pend_next_c = pend_next_c - CW'(1);
  end

  always_ff @(posedge emif_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) pending_words <= '0;
    else              pending_words <= PW_W'(pend_next_c);
  end

  always_ff @(posedge emif_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      rdv_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdv_q <= m0.readdatavalid;
      if (m0.readdatavalid) rdata_q <= m0.readdata;
    end
  end

  always_ff @(posedge emif_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      state_q    <= ST_RUN;
      freeze_ack <= 1'b0;
    end else begin
      state_q    <= state_d;
      freeze_ack <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (freeze_req && (wr_beats_left_q == '0)) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!freeze_req)                          state_d = ST_RUN;
        else if (empty_c && (pending_words == '0)) state_d = ST_FROZEN;
      end
      ST_FROZEN: if (!freeze_req) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    ack_d = 1'b0;
    if (state_d == ST_FROZEN) ack_d = 1'b1;
  end

  assign s0.waitrequest   = wait_c;
  assign s0.readdata      = rdata_q;
  assign s0.readdatavalid = rdv_q;

  assign m0.read        = head_q.read;
  assign m0.write       = head_q.write;
  assign m0.address     = head_q.address;
  assign m0.burstcount  = head_q.burstcount;
  assign m0.writedata   = head_q.writedata;
  assign m0.byteenable  = head_q.byteenable;
  assign m0.debugaccess = head_q.debugaccess;

endmodule
